mandelbrot_tile_engine: RTL

MANDELBROT_TILE_ENGINE -- requirements
Module: mandelbrot_tile_engine

---
 rtl/mandelbrot_tile_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mandelbrot_tile_engine.sv
// Fixed-point Mandelbrot escape-time engine: computes one tile in raster order
// and streams per-pixel iteration counts over a valid/ready handshake.
module mandelbrot_tile_engine #(
  parameter int unsigned BITWIDTH = 11,
  parameter int unsigned FRACBITS = 8,
  parameter int unsigned CTRWIDTH = 7,
  parameter int unsigned XBITS    = 3,
  parameter int unsigned YBITS    = 3,
  parameter int unsigned OUTBITS  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_shift,
  input  logic                cfg_data,
  input  logic                cfg_commit,
  input  logic                start,
  input  logic                abort,
  input  logic [CTRWIDTH-1:0] max_ctr,
  input  logic [1:0]          ctr_select,
  output logic                busy,
  output logic                done,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [OUTBITS-1:0]  pix_count,
  output logic [XBITS-1:0]    pix_x,
  output logic [YBITS-1:0]    pix_y,
  output logic                pix_last
);

  localparam int unsigned SHW = 2 * BITWIDTH + 2;
  localparam int unsigned PW  = 2 * BITWIDTH;
  localparam logic signed [PW-1:0] ESC_LIM = PW'(4) << FRACBITS;

  typedef enum logic [1:0] {IDLE, INIT, ITER, EMIT} state_t;
  state_t state, state_nxt;

  logic [SHW-1:0]             shadow;
  logic [BITWIDTH-1:0]        cr_off, ci_off;
  logic [1:0]                 scaling;
  logic [CTRWIDTH-1:0]        max_lat, ctr;
  logic signed [BITWIDTH-1:0] zr, zi, cr, ci;

  logic signed [PW-1:0]       zr_sq, zi_sq, zr_zi, mag;
  logic signed [BITWIDTH-1:0] zr_nxt, zi_nxt;
  logic                       escape, last_px, accept;

  // One z <- z^2 + c step; the cross term shifts one bit less to fold in the factor 2
  always_comb begin
    zr_sq  = (PW'(zr) * PW'(zr)) >>> FRACBITS;
    zi_sq  = (PW'(zi) * PW'(zi)) >>> FRACBITS;
    zr_zi  = (PW'(zr) * PW'(zi)) >>> (FRACBITS - 1);
    mag    = zr_sq + zi_sq;
    escape = (mag >= ESC_LIM);
    zr_nxt = BITWIDTH'(zr_sq - zi_sq + PW'(cr));
    zi_nxt = BITWIDTH'(zr_zi + PW'(ci));
  end

  assign last_px = (&pix_x) && (&pix_y);

  // Next-state logic; abort overrides everything outside IDLE
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = INIT;
      INIT: state_nxt = ITER;
      ITER: if (escape || (ctr == max_lat)) state_nxt = EMIT;
      EMIT: begin
        if (pix_ready) begin
          accept    = 1'b1;
          state_nxt = last_px ? IDLE : INIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      cr_off    <= '0;
      ci_off    <= '0;
      scaling   <= '0;
      max_lat   <= '0;
      ctr       <= '0;
      zr        <= '0;
      zi        <= '0;
      cr        <= '0;
      ci        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
      pix_count <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      pix_valid <= (state_nxt == EMIT);
      done      <= accept && last_px;

      if (cfg_shift) shadow <= {shadow[SHW-2:0], cfg_data};
      if (cfg_commit && (state == IDLE)) {scaling, ci_off, cr_off} <= shadow;

      if ((state == IDLE) && start) begin
        max_lat <= max_ctr;
        pix_x   <= '0;
        pix_y   <= '0;
      end

      case (state)
        INIT: begin
          cr  <= cr_off + (BITWIDTH'(pix_x) << scaling);
          ci  <= ci_off + (BITWIDTH'(pix_y) << scaling);
          zr  <= '0;
          zi  <= '0;
          ctr <= '0;
        end
        ITER: begin
          if (state_nxt == ITER) begin
            zr  <= zr_nxt;
            zi  <= zi_nxt;
            ctr <= ctr + 1'b1;
          end
        end
        EMIT: begin
          if (accept && !last_px) begin
            pix_x <= pix_x + 1'b1;
            if (&pix_x) pix_y <= pix_y + 1'b1;
          end
        end
        default: ;
      endcase

      // Count is held in EMIT, so the shifted view tracks ctr_select while stalled
      if (state_nxt == EMIT) begin
        pix_count <= OUTBITS'(ctr >> ctr_select);
        pix_last  <= last_px;
      end
    end
  end

endmodule
